// File: rtl/remainder_job_sequencer_18_4.sv
// rtl/remainder_job_sequencer_18_4.sv - job FIFO, launch FSM and result collector for the 18/4 remainder engine
module remainder_job_sequencer_18_4 #(
    parameter int FIFO_DEPTH = 4,
    parameter int WATCHDOG   = 63
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [17:0]                   in_dividend,
    input  logic [3:0]                    in_divisor,
    input  logic [3:0]                    in_tag,
    output logic                          eng_start,
    output logic [17:0]                   eng_dividend,
    output logic [3:0]                    eng_orgdiv,
    input  logic [3:0]                    eng_result,
    input  logic                          eng_result_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [3:0]                    out_rem,
    output logic [3:0]                    out_tag,
    output logic                          out_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = AW + 1;
    localparam int WD_W  = $clog2(WATCHDOG + 1);
    localparam logic [LW-1:0]   FULL_LEVEL = LW'(FIFO_DEPTH);
    localparam logic [WD_W-1:0] WD_LAST    = WD_W'(WATCHDOG - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t state;

    // Job FIFO storage: {dividend, divisor, tag}
    logic [17:0]   mem_dividend [FIFO_DEPTH];
    logic [3:0]    mem_divisor  [FIFO_DEPTH];
    logic [3:0]    mem_tag      [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;

    // Job register: feeds the engine operands so they stay put for the whole run
    logic [17:0]   job_dividend;
    logic [3:0]    job_divisor;
    logic [3:0]    job_tag;
    logic [WD_W-1:0] wd_cnt;

    logic push;
    logic pop;

    assign in_ready     = (level != FULL_LEVEL);
    assign push         = in_valid & in_ready;
    assign pop          = (state == S_IDLE) && (level != '0);
    assign fifo_level   = level;
    assign eng_dividend = job_dividend;
    assign eng_orgdiv   = job_divisor;

    // FIFO payload write; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem_dividend[wr_ptr] <= in_dividend;
            mem_divisor[wr_ptr]  <= in_divisor;
            mem_tag[wr_ptr]      <= in_tag;
        end
    end

    // FIFO pointers and occupancy; push and pop in the same cycle leave the level unchanged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

    // Job sequencing FSM with registered engine launch and result outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            job_dividend <= '0;
            job_divisor  <= '0;
            job_tag      <= '0;
            wd_cnt       <= '0;
            eng_start    <= 1'b0;
            out_valid    <= 1'b0;
            out_rem      <= '0;
            out_tag      <= '0;
            out_err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        job_dividend <= mem_dividend[rd_ptr];
                        job_divisor  <= mem_divisor[rd_ptr];
                        job_tag      <= mem_tag[rd_ptr];
                        state        <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!job_divisor[3]) begin
                        // The engine only works with a normalised divisor; skip it entirely
                        out_err   <= 1'b1;
                        out_rem   <= '0;
                        out_tag   <= job_tag;
                        out_valid <= 1'b1;
                        state     <= S_OUT;
                    end else begin
                        eng_start <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    eng_start <= 1'b0;
                    wd_cnt    <= '0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (eng_result_ready) begin
                        out_rem   <= eng_result;
                        out_err   <= 1'b0;
                        out_tag   <= job_tag;
                        out_valid <= 1'b1;
                        state     <= S_OUT;
                    end else if (wd_cnt == WD_LAST) begin
                        // Engine never finished: report the job as failed
                        out_rem   <= '0;
                        out_err   <= 1'b1;
                        out_tag   <= job_tag;
                        out_valid <= 1'b1;
                        state     <= S_OUT;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    eng_start <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_remainder_job_sequencer_18_4.sv
// tb/tb_remainder_job_sequencer_18_4.sv - directed bench for the remainder job sequencer
module tb_remainder_job_sequencer_18_4;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_dividend;
    logic [3:0]  in_divisor;
    logic [3:0]  in_tag;
    logic        eng_start;
    logic [17:0] eng_dividend;
    logic [3:0]  eng_orgdiv;
    logic [3:0]  eng_result;
    logic        eng_result_ready;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_rem;
    logic [3:0]  out_tag;
    logic        out_err;
    logic [2:0]  fifo_level;

    int vectors;
    int miscompares;

    remainder_job_sequencer_18_4 dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_dividend      (in_dividend),
        .in_divisor       (in_divisor),
        .in_tag           (in_tag),
        .eng_start        (eng_start),
        .eng_dividend     (eng_dividend),
        .eng_orgdiv       (eng_orgdiv),
        .eng_result       (eng_result),
        .eng_result_ready (eng_result_ready),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_rem          (out_rem),
        .out_tag          (out_tag),
        .out_err          (out_err),
        .fifo_level       (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine model: fixed latency, operands latched at start, optional hang
    logic        eng_busy;
    logic        eng_abandon;
    logic        hang;
    int          eng_cnt;
    logic [17:0] m_div;
    logic [3:0]  m_org;
    int          start_cnt;
    int          overlap_cnt;
    int          stab_err;

    initial begin
        eng_busy    = 1'b0;
        eng_abandon = 1'b0;
        eng_cnt     = 0;
        eng_result  = '0;
        m_div       = '0;
        m_org       = '0;
        start_cnt   = 0;
        overlap_cnt = 0;
        stab_err    = 0;
    end

    assign eng_result_ready = ~eng_busy & ~eng_start;

    always @(posedge clk) begin
        if (reset) begin
            eng_abandon <= 1'b1;
        end else if (eng_start) begin
            if (eng_busy && !eng_abandon) overlap_cnt <= overlap_cnt + 1;
            start_cnt   <= start_cnt + 1;
            eng_busy    <= 1'b1;
            eng_abandon <= hang;
            eng_cnt     <= 20;
            m_div       <= eng_dividend;
            m_org       <= eng_orgdiv;
            eng_result  <= 4'(eng_dividend % 18'(eng_orgdiv));
        end else if (eng_busy && !eng_abandon) begin
            if (eng_dividend !== m_div || eng_orgdiv !== m_org) stab_err <= stab_err + 1;
            if (eng_cnt == 0) eng_busy <= 1'b0;
            else eng_cnt <= eng_cnt - 1;
        end
    end

    task automatic push(input logic [17:0] d, input logic [3:0] v, input logic [3:0] t);
        int n;
        in_valid    = 1'b1;
        in_dividend = d;
        in_divisor  = v;
        in_tag      = t;
        n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!in_ready) begin
            miscompares++;
            $display("FAIL push_timeout tag=%0d in_ready=%b required 1", t, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input logic [3:0] rem, input logic [3:0] tag, input logic err);
        int n;
        out_ready = 1'b1;
        n = 0;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!out_valid) begin
            miscompares++;
            $display("FAIL result_timeout tag=%0d out_valid=%b required 1", tag, out_valid);
        end else if (out_rem !== rem || out_tag !== tag || out_err !== err) begin
            miscompares++;
            $display("FAIL result rem/tag/err=%0d/%0d/%b required %0d/%0d/%b",
                     out_rem, out_tag, out_err, rem, tag, err);
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        vectors++;
        if (in_ready !== 1'b1 || eng_start !== 1'b0 || eng_dividend !== 18'd0 || eng_orgdiv !== 4'd0 ||
            out_valid !== 1'b0 || out_rem !== 4'd0 || out_tag !== 4'd0 || out_err !== 1'b0 ||
            fifo_level !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_values rdy=%b st=%b div=%0d org=%0d ov=%b rem=%0d tag=%0d err=%b lvl=%0d required 1,0,0,0,0,0,0,0,0",
                     in_ready, eng_start, eng_dividend, eng_orgdiv, out_valid, out_rem, out_tag, out_err, fifo_level);
        end
    endtask

    task automatic test_single_job;
        int s0;
        int n;
        s0 = start_cnt;
        push(18'd12345, 4'd11, 4'd3);
        n = 0;
        while (!eng_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (eng_orgdiv !== 4'd11 || eng_dividend !== 18'd12345) begin
            miscompares++;
            $display("FAIL operands_in_wait org=%0d div=%0d required 11 12345", eng_orgdiv, eng_dividend);
        end
        collect(4'd3, 4'd3, 1'b0);
        vectors++;
        if (start_cnt - s0 !== 1) begin
            miscompares++;
            $display("FAIL single_start_count got %0d required 1", start_cnt - s0);
        end
    endtask

    task automatic test_two_jobs;
        int s0;
        s0 = start_cnt;
        push(18'd262143, 4'd15, 4'd9);
        push(18'd7, 4'd13, 4'd1);
        collect(4'd3, 4'd9, 1'b0);
        collect(4'd7, 4'd1, 1'b0);
        vectors++;
        if (start_cnt - s0 !== 2) begin
            miscompares++;
            $display("FAIL two_job_starts got %0d required 2", start_cnt - s0);
        end
        vectors++;
        if (overlap_cnt !== 0) begin
            miscompares++;
            $display("FAIL engine_overlap got %0d required 0", overlap_cnt);
        end
    endtask

    task automatic test_illegal_divisor;
        int s0;
        int n;
        s0 = start_cnt;
        out_ready = 1'b1;
        push(18'd1000, 4'd5, 4'd2);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n !== 2) begin
            miscompares++;
            $display("FAIL illegal_latency got %0d required 2", n);
        end
        collect(4'd0, 4'd2, 1'b1);
        repeat (5) @(negedge clk);
        vectors++;
        if (start_cnt !== s0) begin
            miscompares++;
            $display("FAIL illegal_no_start got %0d starts required 0", start_cnt - s0);
        end
    endtask

    task automatic test_back_to_back;
        int s0;
        out_ready = 1'b0;
        s0 = start_cnt;
        push(18'd100, 4'd8, 4'd4);
        push(18'd50, 4'd9, 4'd5);
        push(18'd1000, 4'd12, 4'd6);
        push(18'd17, 4'd10, 4'd7);
        push(18'd255, 4'd14, 4'd8);
        repeat (60) @(negedge clk);
        vectors++;
        if (fifo_level !== 3'd4 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fifo_full level=%0d in_ready=%b required 4 0", fifo_level, in_ready);
        end
        vectors++;
        if (out_valid !== 1'b1 || start_cnt - s0 !== 1) begin
            miscompares++;
            $display("FAIL backpressure out_valid=%b starts=%0d required 1 1", out_valid, start_cnt - s0);
        end
        collect(4'd4, 4'd4, 1'b0);
        collect(4'd5, 4'd5, 1'b0);
        collect(4'd4, 4'd6, 1'b0);
        collect(4'd7, 4'd7, 1'b0);
        collect(4'd3, 4'd8, 1'b0);
    endtask

    task automatic test_watchdog;
        int n;
        out_ready = 1'b1;
        hang = 1'b1;
        push(18'd999, 4'd9, 4'd10);
        push(18'd40, 4'd11, 4'd11);
        n = 0;
        while (!eng_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n !== 64) begin
            miscompares++;
            $display("FAIL watchdog_latency got %0d required 64", n);
        end
        collect(4'd0, 4'd10, 1'b1);
        hang = 1'b0;
        collect(4'd7, 4'd11, 1'b0);
    endtask

    task automatic test_reset_mid_job;
        int n;
        int s0;
        out_ready = 1'b1;
        push(18'd300, 4'd8, 4'd12);
        push(18'd301, 4'd8, 4'd13);
        push(18'd302, 4'd8, 4'd14);
        n = 0;
        while (!eng_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (fifo_level !== 3'd2) begin
            miscompares++;
            $display("FAIL queued_before_reset level=%0d required 2", fifo_level);
        end
        reset = 1'b1;
        #1;
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        s0 = start_cnt;
        n = 0;
        repeat (60) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        vectors++;
        if (n !== 0 || start_cnt !== s0) begin
            miscompares++;
            $display("FAIL stale_after_reset valid_cycles=%0d starts=%0d required 0 0", n, start_cnt - s0);
        end
        push(18'd303, 4'd8, 4'd15);
        collect(4'd7, 4'd15, 1'b0);
        vectors++;
        if (stab_err !== 0) begin
            miscompares++;
            $display("FAIL operand_stability got %0d changes required 0", stab_err);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        hang        = 1'b0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        in_tag      = '0;
        out_ready   = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_single_job();
        test_two_jobs();
        test_illegal_divisor();
        test_back_to_back();
        test_watchdog();
        test_reset_mid_job();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
